// File: rtl/sdadc_if.sv
// Sample stream from the sigma-delta sequencer: ones count, valid and ready.
interface sdadc_if #(
  parameter int OSR_LOG2 = 8
);
  logic [OSR_LOG2:0] data;
  logic              valid;
  logic              ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/sdadc_ctrl.sv
// Sigma-delta ADC sequencer: closes the comparator/RC loop and counts feedback ones per window.
// Optional SDADC_OVR_EN: continuous windows without HOLD stall, plus a sticky overrun flag.
module sdadc_ctrl #(
  parameter int OSR_LOG2    = 8,
  parameter int SETTLE_CYC  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     en,
  input  logic     cont,
  input  logic     start,
  input  logic     cmp_in,
  output logic     fb_out,
  output logic     busy,
  sdadc_if.master  smp
`ifdef SDADC_OVR_EN
  ,
  output logic     ovr
`endif
);

  localparam int DW    = OSR_LOG2 + 1;
  localparam int SET_W = $clog2(SETTLE_CYC + 1);
  localparam int CNT_W = (OSR_LOG2 > SET_W) ? OSR_LOG2 : SET_W;
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] WIN_LOAD    = CNT_W'((1 << OSR_LOG2) - 1);

  typedef enum logic [1:0] {IDLE, SETTLE, INTEG, HOLD} state_t;

  state_t                 state, state_nxt;
  logic [SYNC_STAGES-1:0] cmp_sync;
  logic                   cmp_s;
  logic [CNT_W-1:0]       cnt;
  logic [DW-1:0]          acc;
  logic [DW-1:0]          acc_sum;
  logic [DW-1:0]          res_p0;
  logic                   vld_p0;
  logic                   load_settle;
  logic                   load_win;
  logic                   win_end;
  logic                   hs;

  assign cmp_s   = cmp_sync[SYNC_STAGES-1];
  assign acc_sum = acc + DW'(fb_out);
  assign hs      = smp.valid & smp.ready;
  assign busy    = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cmp_sync <= '0;
    end else begin
      cmp_sync <= {cmp_sync[SYNC_STAGES-2:0], cmp_in};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    load_settle = 1'b0;
    load_win    = 1'b0;
    win_end     = 1'b0;
    if (!en) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (start | cont) begin
            state_nxt   = SETTLE;
            load_settle = 1'b1;
          end
        end
        SETTLE: begin
          if (cnt == '0) begin
            state_nxt = INTEG;
            load_win  = 1'b1;
          end
        end
        INTEG: begin
          if (cnt == '0) begin
            win_end = 1'b1;
`ifdef SDADC_OVR_EN
            if (cont) begin
              state_nxt = INTEG;
              load_win  = 1'b1;
            end else begin
              state_nxt = HOLD;
            end
`else
            state_nxt = HOLD;
`endif
          end
        end
        HOLD: begin
          if (hs) begin
            if (cont) begin
              state_nxt = INTEG;
              load_win  = 1'b1;
            end else begin
              state_nxt = IDLE;
            end
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Window counter and ones accumulator; a partial window is simply abandoned on disable.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
      acc <= '0;
    end else if (load_settle) begin
      cnt <= SETTLE_LOAD;
    end else if (load_win) begin
      cnt <= WIN_LOAD;
      acc <= '0;
    end else if (state == SETTLE || state == INTEG) begin
      cnt <= cnt - 1'b1;
      if (state == INTEG) begin
        acc <= acc_sum;
      end
    end
  end

  // Stage p0: window result captured at window end (final feedback bit included).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      res_p0 <= '0;
      vld_p0 <= 1'b0;
    end else begin
      vld_p0 <= win_end;
      if (win_end) begin
        res_p0 <= acc_sum;
      end
    end
  end

  // Stage p1: result published on the stream; feedback bit driven to the RC node.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fb_out    <= 1'b0;
      smp.data  <= '0;
      smp.valid <= 1'b0;
`ifdef SDADC_OVR_EN
      ovr       <= 1'b0;
`endif
    end else begin
      fb_out <= (en && state != IDLE) ? cmp_s : 1'b0;
      if (!en) begin
        smp.valid <= 1'b0;
`ifdef SDADC_OVR_EN
        ovr       <= 1'b0;
`endif
      end else if (vld_p0) begin
        smp.data  <= res_p0;
        smp.valid <= 1'b1;
`ifdef SDADC_OVR_EN
        if (smp.valid && !smp.ready) begin
          ovr <= 1'b1;
        end
`endif
      end else if (hs) begin
        smp.valid <= 1'b0;
      end
    end
  end

endmodule
